level_meter_scheduler: RTL and testbench
========================================

# level_meter_scheduler

Shares one section-peak engine between `channels` audio-level streams (e.g. L/R absolute sample magnitudes) feeding the level meter. Each accepted sample updates that channel's running section maximum. After every `sample_count` accepted samples the channel's peak is handed to a single tagged output stream consumed by the display/peak-hold logic. Round-robin arbitration on input and output; per-channel one-deep result buffering with lossless backpressure.

## Interface
- `width`, 15: magnitude bit width (unsigned).
- `channels`, 2: number of input streams, 2..8.
- `sample_count`, 735: samples per section per channel (60 fps at 44.1 kHz), ≥2.
- `clk`  in  1: single clock, all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `i_valid`  in  `channels`: per-channel sample valid.
- `i_ready`  out  `channels`: per-channel accept; at most one bit high per cycle.
- `i_value`  in  `channels*width`: channel c at bits [c*width +: width].
- `o_valid`  out  1: result valid, held until accepted.
- `o_ready`  in  1: downstream accept.
- `o_channel`  out  `$clog2(channels)`: channel of result.
- `o_value`  out  `width`: section maximum.

## Operation
- Per-channel state: `max_value[c]` (width), `count[c]` (0..sample_count-1), `res_valid[c]`, `res_value[c]`.
- Eligible(c) = `i_valid[c]` && !(`count[c]==sample_count-1` && `res_valid[c]` && !drain(c)). drain(c) = output stage loading channel c this cycle.
- Input arbiter: round-robin over eligible channels, search starts at last granted+1; `i_ready` = one-hot grant. A transfer is `i_valid[c] && i_ready[c]`.
- On transfer, `count[c] < sample_count-1`: `max_value[c] <= max(max_value[c], v)`, `count[c]++`.
- On transfer, `count[c] == sample_count-1`: `res_value[c] <= max(max_value[c], v)`, `res_valid[c] <= 1`, `max_value[c] <= 0`, `count[c] <= 0`.
- Output stage: loads when `!o_valid || o_ready`. It picks a channel round-robin among `res_valid` (independent pointer), copies `res_value`/index to `o_value`/`o_channel`, sets `o_valid`, and clears that `res_valid`. With none pending and `o_ready`, `o_valid <= 0`.
- Same-cycle drain and refill of `res_valid[c]`: refill wins (set), no loss.
- Comparison is unsigned, full width. No saturation needed. Values are never modified.
- `i_ready` is combinational from `i_valid` and state. Sources must not derive `i_valid` from `i_ready`.

## Timing
- Reset values: `o_valid`=0, `o_value`=0, `o_channel`=0, all `res_valid`/`count`/`max_value`=0. Both arbiter pointers point to `channels-1`, so channel 0 has first priority. `i_ready`=0 while `reset` is high.
- Reset mid-section discards partial sections and pending results. `o_valid` is 0 the cycle after reset is sampled.
- Latency: last sample accepted at cycle N → `res_valid` at N+1 → `o_valid` at N+2 (if output stage free).
- Throughput: one input sample per cycle total; one result per cycle out.
- Backpressure: a channel stalls only on its section-ending sample while its previous result is still pending. Other channels keep flowing.
- `o_valid`/`o_channel`/`o_value` are stable while `o_valid && !o_ready`.

## Structure
- Package `level_meter_pkg`: default `width`/`sample_count` constants, `ch_idx_t` width function `$clog2(channels)`.
- Sub-module `round_robin_arbiter` (param `n`; `req`, `advance`, one-hot `grant`, `grant_idx`; pointer updates on `advance`). Instantiated twice: input and output.
- Per-channel state is in arrays in the top module. Only one comparator exists (shared datapath, muxed by the grant index).

## Test plan
- channels=2, sample_count=4, o_ready=1; ch0 sends 3,9,2,5 → one result ch0/9, `o_valid` 2 cycles after 4th accept, high 1 cycle.
- Both `i_valid` held high → grants alternate 0,1,0,1; `i_ready` never 2'b11; after 8 cycles, results ch0 and ch1 each emitted once in round-robin order.
- o_ready=0; ch0 streams 8 samples → first result held on output, second in `res_valid[0]`, 9th-section-end stalls (`i_ready[0]`=0); ch1 still accepted. Release o_ready → both ch0 results in order, no loss.
- Sections of all 0x7FFF then all 0 → outputs 32767 then 0 (max resets per section).
- Two samples into ch0 section, pulse reset 1 cycle → `o_valid`=0; next result reflects only 4 post-reset samples.
- Drain and refill of `res_valid[1]` in the same cycle → both results delivered, `o_channel`=1 twice.

Source files
------------

// File: rtl/level_meter_pkg.sv
// Shared constants and helpers for the level-meter section-peak scheduler.
//   default_width        : default magnitude width in bits
//   default_channels     : default number of input streams
//   default_sample_count : default samples per section (60 fps at 44.1 kHz)
//   ch_idx_width()       : bit width of a channel index (at least 1)
package level_meter_pkg;

    localparam int unsigned default_width        = 15;
    localparam int unsigned default_channels     = 2;
    localparam int unsigned default_sample_count = 735;

    // Width of a channel index for n channels; never zero so ports stay legal.
    function automatic int unsigned ch_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index.
//   clk, reset : clock, synchronous active-high reset (pointer -> n-1)
//   req        : request vector
//   advance    : latch the current grant as the new "last granted"
//   grant      : one-hot grant (combinational)
//   grant_idx  : index of the granted request (combinational)
module round_robin_arbiter
    import level_meter_pkg::*;
#(
    parameter int unsigned n = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [n-1:0]               req,
    input  logic                       advance,
    output logic [n-1:0]               grant,
    output logic [ch_idx_width(n)-1:0] grant_idx
);

    localparam int unsigned iw = ch_idx_width(n);

    logic [iw-1:0] last_q;
    logic          found;

    // Prefer requests above the pointer, then wrap to the lowest request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!found && req[i] && (iw'(i) > last_q)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = iw'(i);
            end
        end
        for (int i = 0; i < n; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = iw'(i);
            end
        end
    end

    // Pointer register; reset gives index 0 first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= iw'(n - 1);
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/level_meter_scheduler.sv
// Shares one section-peak engine between several magnitude streams and emits
// each channel's section maximum on a single tagged output stream.
//   clk, reset : clock, synchronous active-high reset
//   i_valid    : per-channel sample valid
//   i_ready    : per-channel accept, one-hot or zero (combinational)
//   i_value    : packed samples, channel c at [c*width +: width]
//   o_valid    : result valid, held until o_ready
//   o_ready    : downstream accept
//   o_channel  : channel of the result
//   o_value    : section maximum of that channel
module level_meter_scheduler
    import level_meter_pkg::*;
#(
    parameter int unsigned width        = default_width,
    parameter int unsigned channels     = default_channels,
    parameter int unsigned sample_count = default_sample_count
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [channels-1:0]               i_valid,
    output logic [channels-1:0]               i_ready,
    input  logic [channels*width-1:0]         i_value,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [ch_idx_width(channels)-1:0] o_channel,
    output logic [width-1:0]                  o_value
);

    localparam int unsigned      cw         = ch_idx_width(channels);
    localparam int unsigned      cnt_w      = $clog2(sample_count);
    localparam logic [cnt_w-1:0] count_last = cnt_w'(sample_count - 1);

    logic [width-1:0]    max_value [channels];
    logic [cnt_w-1:0]    count     [channels];
    logic [width-1:0]    res_value [channels];
    logic [channels-1:0] res_valid;
    logic [channels-1:0] res_valid_nxt;
    logic [width-1:0]    in_value  [channels];

    logic                out_load;
    logic [channels-1:0] out_grant;
    logic [cw-1:0]       out_idx;
    logic [channels-1:0] drain;
    logic [channels-1:0] eligible;
    logic [channels-1:0] in_req;
    logic [channels-1:0] in_grant;
    logic [cw-1:0]       in_idx;
    logic                transfer;
    logic                at_end;
    logic [width-1:0]    sel_value;
    logic [width-1:0]    sel_max;
    logic [width-1:0]    merged;

    // Output register is free to take a new result this cycle.
    assign out_load = !o_valid || o_ready;
    assign drain    = out_load ? out_grant : '0;

    // Unpack samples; a section-ending sample waits only while its slot is full
    // and not being drained in the same cycle.
    always_comb begin
        for (int c = 0; c < channels; c++) begin
            in_value[c] = i_value[c*width +: width];
            eligible[c] = i_valid[c] &&
                          !((count[c] == count_last) && res_valid[c] && !drain[c]);
        end
    end

    assign in_req  = reset ? '0 : eligible;
    assign i_ready = in_grant;

    round_robin_arbiter #(.n(channels)) u_in_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (in_req),
        .advance   (transfer),
        .grant     (in_grant),
        .grant_idx (in_idx)
    );

    round_robin_arbiter #(.n(channels)) u_out_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (res_valid),
        .advance   (out_load && (|res_valid)),
        .grant     (out_grant),
        .grant_idx (out_idx)
    );

    // Single shared comparator, muxed by the input grant.
    always_comb begin
        transfer  = |in_grant;
        sel_value = in_value[in_idx];
        sel_max   = max_value[in_idx];
        merged    = (sel_value > sel_max) ? sel_value : sel_max;
        at_end    = (count[in_idx] == count_last);
    end

    // A refill in the same cycle as a drain keeps the slot occupied.
    always_comb begin
        res_valid_nxt = (res_valid & ~drain) | ((transfer && at_end) ? in_grant : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < channels; c++) begin
                max_value[c] <= '0;
                count[c]     <= '0;
                res_value[c] <= '0;
            end
            res_valid <= '0;
            o_valid   <= 1'b0;
            o_value   <= '0;
            o_channel <= '0;
        end else begin
            if (out_load) begin
                if (|res_valid) begin
                    o_valid   <= 1'b1;
                    o_value   <= res_value[out_idx];
                    o_channel <= out_idx;
                end else begin
                    o_valid   <= 1'b0;
                end
            end
            res_valid <= res_valid_nxt;
            if (transfer) begin
                if (at_end) begin
                    res_value[in_idx] <= merged;
                    max_value[in_idx] <= '0;
                    count[in_idx]     <= '0;
                end else begin
                    max_value[in_idx] <= merged;
                    count[in_idx]     <= count[in_idx] + cnt_w'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_level_meter_scheduler.sv
// Directed bench for level_meter_scheduler (2 channels, 4-sample sections).
// A monitor collects accepted samples per channel, forms section maxima and
// scores every output handshake; directed steps pin timing and arbitration.
module tb_level_meter_scheduler;

    localparam int W  = 15;
    localparam int CH = 2;
    localparam int SC = 4;

    logic            clk;
    logic            reset;
    logic [CH-1:0]   i_valid;
    logic [CH-1:0]   i_ready;
    logic [CH*W-1:0] i_value;
    logic            o_valid;
    logic            o_ready;
    logic            o_channel;
    logic [W-1:0]    o_value;

    int total = 0;
    int bad   = 0;

    int sec_q [CH][$];
    int exp_q [CH][$];

    logic         prev_hold;
    logic         prev_ch;
    logic [W-1:0] prev_val;

    level_meter_scheduler #(
        .width        (W),
        .channels     (CH),
        .sample_count (SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_value   (i_value),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_channel (o_channel),
        .o_value   (o_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input int v, input int ch, input int val);
        check({name, "_valid"}, int'(o_valid), v);
        if (v != 0) begin
            check({name, "_channel"}, int'(o_channel), ch);
            check({name, "_value"}, int'(o_value), val);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Offer one sample on a channel and wait (bounded) for it to be taken.
    task automatic send(input int ch, input int v);
        int waited = 0;
        i_valid[ch]         = 1'b1;
        i_value[ch*W +: W]  = W'(v);
        @(negedge clk);
        while (!i_ready[ch] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("send_accept", int'(i_ready[ch]), 1);
        tick();
        i_valid[ch] = 1'b0;
    endtask

    // Wait (bounded) for the next valid output and compare it.
    task automatic expect_out(input string name, input int ch, input int val);
        int waited = 0;
        @(negedge clk);
        while (!o_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_out(name, 1, ch, val);
        tick();
    endtask

    // Reference behaviour: section maximum of every SC accepted samples,
    // delivered per channel in order, outputs frozen while stalled.
    always @(negedge clk) begin
        int m;
        int oc;
        if (reset) begin
            check("ready_in_reset", int'(i_ready), 0);
            for (int c = 0; c < CH; c++) begin
                sec_q[c].delete();
                exp_q[c].delete();
            end
            prev_hold = 1'b0;
        end else begin
            check("ready_legal", int'(($countones(i_ready) <= 1) && ((i_ready & ~i_valid) == '0)), 1);
            for (int c = 0; c < CH; c++) begin
                if (i_valid[c] && i_ready[c]) begin
                    sec_q[c].push_back(int'(i_value[c*W +: W]));
                    if (sec_q[c].size() == SC) begin
                        m = 0;
                        for (int k = 0; k < sec_q[c].size(); k++) begin
                            if (sec_q[c][k] > m) m = sec_q[c][k];
                        end
                        exp_q[c].push_back(m);
                        sec_q[c].delete();
                    end
                end
            end
            if (prev_hold) begin
                check("hold_valid", int'(o_valid), 1);
                check("hold_channel", int'(o_channel), int'(prev_ch));
                check("hold_value", int'(o_value), int'(prev_val));
            end
            if (o_valid && o_ready) begin
                oc = int'(o_channel);
                check("output_expected", int'(exp_q[oc].size() != 0), 1);
                if (exp_q[oc].size() != 0) begin
                    check("model_value", int'(o_value), exp_q[oc].pop_front());
                end
            end
            prev_hold = o_valid && !o_ready;
            prev_ch   = o_channel;
            prev_val  = o_value;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a[4];
        int b[4];
        int k0;
        int k1;

        reset     = 1'b1;
        i_valid   = 2'b11;
        i_value   = '0;
        o_ready   = 1'b1;
        prev_hold = 1'b0;
        repeat (2) tick();
        i_valid = 2'b00;
        reset   = 1'b0;
        check_out("reset_state", 0, 0, 0);
        check("reset_o_value", int'(o_value), 0);
        check("reset_o_channel", int'(o_channel), 0);

        // Single section on ch0: 3,9,2,5 -> 9, valid two cycles after last accept.
        a = '{3, 9, 2, 5};
        for (int j = 0; j < 4; j++) send(0, a[j]);
        check_out("lat_n1", 0, 0, 0);
        tick();
        check_out("lat_n2", 1, 0, 9);
        tick();
        check_out("lat_n3", 0, 0, 0);

        // Both channels streaming: grants alternate starting at ch0.
        do_reset();
        a = '{1, 2, 3, 4};
        b = '{10, 20, 5, 7};
        k0 = 0;
        k1 = 0;
        i_valid = 2'b11;
        for (int cyc = 0; cyc < 8; cyc++) begin
            i_value[0 +: W] = W'(a[k0 & 3]);
            i_value[W +: W] = W'(b[k1 & 3]);
            @(negedge clk);
            check("rr_grant", int'(i_ready), ((cyc % 2) == 0) ? 1 : 2);
            if (i_ready[0]) k0++;
            if (i_ready[1]) k1++;
            tick();
        end
        i_valid = 2'b00;
        check_out("rr_out0", 1, 0, 4);
        tick();
        check_out("rr_out1", 1, 1, 20);
        tick();
        check_out("rr_idle", 0, 0, 0);

        // Backpressure: two ch0 results buffered, third section end stalls.
        do_reset();
        o_ready = 1'b0;
        a = '{1, 2, 3, 4};
        for (int j = 0; j < 4; j++) send(0, a[j]);
        a = '{6, 1, 1, 1};
        for (int j = 0; j < 4; j++) send(0, a[j]);
        a = '{2, 3, 9, 0};
        for (int j = 0; j < 3; j++) send(0, a[j]);
        i_valid = 2'b11;
        i_value[0 +: W] = W'(1);
        for (int j = 0; j < 3; j++) begin
            i_value[W +: W] = W'(100 * (j + 1));
            @(negedge clk);
            check("stall_grant", int'(i_ready), 2);
            tick();
        end
        i_valid[1] = 1'b0;
        check_out("held_a", 1, 0, 4);
        o_ready = 1'b1;
        @(negedge clk);
        check("release_grant", int'(i_ready), 1);
        tick();
        i_valid = 2'b00;
        check_out("bp_b", 1, 0, 6);
        tick();
        check_out("bp_c", 1, 0, 9);
        tick();
        check_out("bp_idle", 0, 0, 0);

        // Full-scale section followed by an all-zero section.
        do_reset();
        for (int j = 0; j < 4; j++) send(0, 32767);
        expect_out("full_scale", 0, 32767);
        for (int j = 0; j < 4; j++) send(0, 0);
        expect_out("zero_section", 0, 0);

        // Reset mid-section discards the partial section and the held result.
        do_reset();
        o_ready = 1'b0;
        for (int j = 0; j < 4; j++) send(0, 7);
        send(0, 50);
        send(0, 60);
        check("pre_reset_valid", int'(o_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_out("post_reset", 0, 0, 0);
        o_ready = 1'b1;
        a = '{1, 2, 3, 4};
        for (int j = 0; j < 4; j++) send(0, a[j]);
        expect_out("post_reset_sec", 0, 4);

        // Drain and refill of ch1's result slot in the same cycle.
        do_reset();
        o_ready = 1'b0;
        a = '{1, 2, 3, 4};
        for (int j = 0; j < 4; j++) send(1, a[j]);
        a = '{10, 11, 12, 13};
        for (int j = 0; j < 4; j++) send(1, a[j]);
        a = '{20, 21, 22, 0};
        for (int j = 0; j < 3; j++) send(1, a[j]);
        i_valid[1] = 1'b1;
        i_value[W +: W] = W'(23);
        o_ready = 1'b1;
        @(negedge clk);
        check("refill_grant", int'(i_ready), 2);
        tick();
        i_valid = 2'b00;
        check_out("refill_first", 1, 1, 13);
        tick();
        check_out("refill_second", 1, 1, 23);
        tick();
        check_out("refill_idle", 0, 0, 0);

        repeat (2) tick();
        check("leftover_ch0", exp_q[0].size(), 0);
        check("leftover_ch1", exp_q[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
